// File: rtl/multi_channel_event_counter_pkg.sv
// Shared constants, helpers and the counter-update action type for the
// multi-channel event counter and its per-channel debouncer.
package counter_pkg;

  // 10 ms at 100 MHz.
  localparam int DEB_CYCLES_10MS = 1_000_000;
  localparam int SYNC_STAGES_DEF = 2;

  // Width of a channel index; a single channel still gets a 1-bit select.
  function automatic int ch_idx_w(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

  // Width of a down-counter that must hold the value deb_cycles.
  function automatic int deb_cnt_w(input int deb_cycles);
    return (deb_cycles > 1) ? $clog2(deb_cycles + 1) : 1;
  endfunction

  // Decoded per-channel action for one clock edge.
  typedef enum logic [2:0] {
    UPD_HOLD       = 3'd0,
    UPD_CLEAR      = 3'd1,
    UPD_INC        = 3'd2,
    UPD_DEC        = 3'd3,
    UPD_LIMIT_HOLD = 3'd4,
    UPD_LIMIT_WRAP = 3'd5
  } upd_t;

endpackage

// File: rtl/channel_debouncer.sv
// One channel of input conditioning: synchroniser, stable-window debouncer
// and rising-edge detector on the debounced level.
module channel_debouncer
  import counter_pkg::*;
#(
  parameter int DEB_CYCLES  = DEB_CYCLES_10MS,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic sw_raw,
  output logic stable,
  output logic rise
);

  localparam int CW = deb_cnt_w(DEB_CYCLES);
  localparam logic [CW-1:0] RELOAD = CW'(DEB_CYCLES);
  localparam logic [CW-1:0] ONE    = CW'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [CW-1:0]          deb_cnt;
  logic                   stable_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sw_raw};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // The counter only runs while the synced level disagrees with the accepted
  // level; any agreement restarts the window, so short glitches are dropped.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      deb_cnt  <= RELOAD;
      stable   <= 1'b0;
      stable_d <= 1'b0;
    end else begin
      stable_d <= stable;
      if (s != stable) begin
        if (deb_cnt == ONE) begin
          stable  <= s;
          deb_cnt <= RELOAD;
        end else begin
          deb_cnt <= deb_cnt - ONE;
        end
      end else begin
        deb_cnt <= RELOAD;
      end
    end
  end

  assign rise = stable & ~stable_d;

endmodule

// File: rtl/multi_channel_event_counter.sv
// N_CH debounced inputs, each feeding a wrap/saturate up/down event counter
// with a sticky limit flag; one count is muxed out for the display.
module multi_channel_event_counter
  import counter_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int CNT_W       = 8,
  parameter int DEB_CYCLES  = DEB_CYCLES_10MS,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  localparam int SEL_W      = ch_idx_w(N_CH)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [N_CH-1:0]        sw,
  input  logic [N_CH-1:0]        dir,
  input  logic                   sat_en,
  input  logic [N_CH-1:0]        clear,
  input  logic [SEL_W-1:0]       sel,
  output logic [CNT_W-1:0]       count_sel,
  output logic [N_CH*CNT_W-1:0]  counts,
  output logic [N_CH-1:0]        stable,
  output logic [N_CH-1:0]        event_pulse,
  output logic [N_CH-1:0]        limit
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [N_CH-1:0]  rise;
  logic [CNT_W-1:0] cnt_arr [N_CH];

  for (genvar i = 0; i < N_CH; i++) begin : g_ch

    channel_debouncer #(
      .DEB_CYCLES  (DEB_CYCLES),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_deb (
      .clock  (clock),
      .reset  (reset),
      .sw_raw (sw[i]),
      .stable (stable[i]),
      .rise   (rise[i])
    );

    upd_t             upd;
    logic             at_limit;
    logic [CNT_W-1:0] cnt_q;
    logic             lim_q;
    logic             pulse_q;

    // dir and sat_en are taken as they stand on the updating edge.
    always_comb begin
      at_limit = dir[i] ? (cnt_q == CNT_MAX) : (cnt_q == CNT_ZERO);
      upd      = UPD_HOLD;
      if (clear[i]) begin
        upd = UPD_CLEAR;
      end else if (rise[i]) begin
        if (at_limit) begin
          upd = sat_en ? UPD_LIMIT_HOLD : UPD_LIMIT_WRAP;
        end else begin
          upd = dir[i] ? UPD_INC : UPD_DEC;
        end
      end
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        cnt_q   <= '0;
        lim_q   <= 1'b0;
        pulse_q <= 1'b0;
      end else begin
        pulse_q <= rise[i];
        case (upd)
          UPD_CLEAR: begin
            cnt_q <= '0;
            lim_q <= 1'b0;
          end
          UPD_INC: cnt_q <= cnt_q + CNT_ONE;
          UPD_DEC: cnt_q <= cnt_q - CNT_ONE;
          UPD_LIMIT_HOLD: lim_q <= 1'b1;
          UPD_LIMIT_WRAP: begin
            cnt_q <= dir[i] ? CNT_ZERO : CNT_MAX;
            lim_q <= 1'b1;
          end
          default: ;
        endcase
      end
    end

    assign cnt_arr[i]                  = cnt_q;
    assign counts[i*CNT_W +: CNT_W]    = cnt_q;
    assign limit[i]                    = lim_q;
    assign event_pulse[i]              = pulse_q;
  end

  // An out-of-range select matches no channel and reads as zero.
  always_comb begin
    count_sel = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (SEL_W'(k) == sel) begin
        count_sel = cnt_arr[k];
      end
    end
  end

endmodule

// File: doc/multi_channel_event_counter.md
# multi_channel_event_counter

Parametrised successor to the single-switch debounced counter. Takes `N_CH` raw switch or button inputs and synchronises and debounces each one. Every debounced rising edge is counted in a per-channel up/down counter that either wraps or saturates, all in the single `clock` domain with no derived clocks. One channel's count is multiplexed out for the seven-segment display FSM; all counts, debounced levels and event pulses are exported for other consumers.

## Interface
Parameters:
- `N_CH`, 4: number of input channels (1–16).
- `CNT_W`, 8: counter width per channel.
- `DEB_CYCLES`, 1000000: consecutive stable cycles required to accept a level change (≥1; 10 ms at 100 MHz).
- `SYNC_STAGES`, 2: synchroniser flops per channel (≥2).

Ports:
- `clock`, in, 1: system clock. Single clock; all logic on rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `sw`, in, N_CH: raw asynchronous switch/button levels.
- `dir`, in, N_CH: per-channel direction; 1 = count up, 0 = count down.
- `sat_en`, in, 1: 1 = saturate at limits, 0 = wrap.
- `clear`, in, N_CH: synchronous per-channel clear of count and flag.
- `sel`, in, max(1,$clog2(N_CH)): channel shown on `count_sel`.
- `count_sel`, out, CNT_W: count of channel `sel`.
- `counts`, out, N_CH*CNT_W: all counts; channel i occupies bits [i*CNT_W +: CNT_W].
- `stable`, out, N_CH: debounced levels.
- `event_pulse`, out, N_CH: one-cycle pulse per accepted rising edge.
- `limit`, out, N_CH: sticky flag, set on wrap or saturation.

## Operation
- Synchroniser: `SYNC_STAGES` flops per channel. The last stage is the synced level `s[i]`.
- Debouncer, per channel:
  - A down-counter of width $clog2(DEB_CYCLES+1) runs while `s[i] != stable[i]` and reloads when they are equal.
  - `stable[i]` toggles on the edge where the mismatch has persisted `DEB_CYCLES` consecutive cycles.
  - A glitch shorter than `DEB_CYCLES` cycles never changes `stable`.
- Edge detect: `rise[i] = stable[i] & ~stable_d[i]`, where `stable_d` is `stable` delayed one cycle. Falling edges are not counted.
- Counter update, per channel, evaluated in priority order each edge:
  - `clear[i]`: count ← 0, `limit[i]` ← 0. Clear wins over a simultaneous event.
  - Else `rise[i]` with `dir[i]`=1:
    - Count below max: count+1.
    - Count at max, `sat_en`=1: hold at max and set `limit`.
    - Count at max, `sat_en`=0: wrap to 0 and set `limit`.
  - Else `rise[i]` with `dir[i]`=0:
    - Count above 0: count−1.
    - Count at 0, `sat_en`=1: hold 0 and set `limit`.
    - Count at 0, `sat_en`=0: wrap to max and set `limit`.
  - Otherwise count holds.
- `limit` is sticky. It clears only on `clear[i]` or `reset`.
- `dir` and `sat_en` are sampled on the edge that performs the update and may change at any time.
- `count_sel`: combinational mux of `counts`. If `sel` ≥ `N_CH`, `count_sel` = 0.
- Reset values: synchroniser flops, `stable`, `stable_d`, `event_pulse`, `counts` and `limit` are all 0; debounce counters are loaded with `DEB_CYCLES`.
- Asserting `reset` mid-debounce or mid-count aborts the operation. After release, a held-high input needs a full `SYNC_STAGES`+`DEB_CYCLES` cycles again before it is accepted.

## Timing
- A raw edge on `sw[i]` that stays clean for the whole window changes `stable[i]` exactly `SYNC_STAGES + DEB_CYCLES` edges after the first edge that samples it. Only ±1 cycle of metastability uncertainty is allowed.
- On the edge after `stable[i]` rises:
  - `event_pulse[i]` goes high for exactly one cycle.
  - `counts[i]` and `limit[i]` update on that same edge, so the new value is visible the cycle `event_pulse` is high.
- `clear[i]` takes effect on the next edge and has 1-cycle latency.
- `count_sel` has zero-cycle latency from `sel` or `counts`.
- Maximum event rate: one per 2·`DEB_CYCLES` cycles per channel. Channels are fully independent, and simultaneous events on all channels must all be counted.

## Structure
- Shared package `counter_pkg`:
  - Default constants for `DEB_CYCLES_10MS` and `SYNC_STAGES`.
  - Channel-index width function.
- Sub-module `channel_debouncer` (params `DEB_CYCLES`, `SYNC_STAGES`; ports `clock`, `reset`, `sw_raw`, `stable`, `rise`), instantiated `N_CH` times in a generate loop.
- The top level holds the counters, flags and output mux.

## Test plan
All scenarios use `N_CH`=2, `CNT_W`=4, `DEB_CYCLES`=4, `SYNC_STAGES`=2.
- Reset and settle: assert `reset` mid-run → all outputs 0 immediately (async). A 3-cycle high glitch on `sw[0]` → `stable` stays 0 and `counts` stays 0.
- Clean press: hold `sw[0]`=1 → `stable[0]` rises 6 edges later, then one `event_pulse[0]` cycle and `counts[0]`=1. Release and press again → `counts[0]`=2.
- Up wrap: `dir`=1, `sat_en`=0, 16 presses → count returns to 0 and `limit[0]`=1. Saturate variant (`sat_en`=1): 20 presses → count=15 and `limit[0]`=1.
- Down limit: `dir[1]`=0, `sat_en`=1, count at 0, one press → count stays 0 and `limit[1]`=1. Same with `sat_en`=0 → count=15.
- Clear priority: `clear[0]` asserted in the same cycle as `rise[0]`, count=7 → count=0 and `limit[0]`=0. Channel 1 is unaffected.
- Simultaneous channels and mux: press both channels at once → each count increments once. `sel`=1 → `count_sel` = `counts[7:4]`.
